// File: rtl/seven_segment_reader.sv
`default_nettype none
// ============================================================================
// Module      : seven_segment_reader
// Description : Recovers a 4-digit BCD frame from multiplexed seven-segment
//               lines using a stability filter and a COLLECT/PRESENT handshake.
//               Optional macro SEG_READER_BLANK_EN decodes 7'h00 as blank (4'hF).
// Revision    : 1.0 - initial release
// ============================================================================
module seven_segment_reader #(
    parameter int STABLE_CNT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  display,
    input  logic [3:0]  an,
    input  logic        sample_en,
    output logic [15:0] bcd_out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        err_code,
    output logic        err_ovf
);

    localparam logic [3:0] CNT_MAX = 4'(STABLE_CNT);
    localparam logic [3:0] CNT_PRE = 4'(STABLE_CNT - 1);

    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        PRESENT = 1'b1
    } state_t;

    state_t      state;
    logic [3:0]  seen;
    logic [3:0]  cnt;
    logic [10:0] prev;
    logic [15:0] digits;

    logic        onehot;
    logic        qualified;
    logic        match;
    logic        accept;
    logic        dec_ok;
    logic [3:0]  dec_val;
    logic [1:0]  idx;
    logic [3:0]  seen_upd;
    logic [10:0] sample;

    assign sample    = {an, display};
    assign onehot    = (an != 4'd0) && ((an & (an - 4'd1)) == 4'd0);
    assign qualified = sample_en && onehot;
    assign match     = (sample == prev);
    // The run is accepted only on the single edge where the count reaches the
    // threshold; once saturated, cnt no longer equals CNT_PRE.
    assign accept    = qualified && match && (cnt == CNT_PRE);
    assign bcd_out   = digits;

    always_comb begin
        dec_ok  = 1'b1;
        dec_val = 4'h0;
        case (display)
            7'h7E:   dec_val = 4'd0;
            7'h30:   dec_val = 4'd1;
            7'h6D:   dec_val = 4'd2;
            7'h79:   dec_val = 4'd3;
            7'h33:   dec_val = 4'd4;
            7'h5B:   dec_val = 4'd5;
            7'h5F:   dec_val = 4'd6;
            7'h70:   dec_val = 4'd7;
            7'h7F:   dec_val = 4'd8;
            7'h7B:   dec_val = 4'd9;
`ifdef SEG_READER_BLANK_EN
            7'h00:   dec_val = 4'hF;
`endif
            default: dec_ok  = 1'b0;
        endcase
    end

    always_comb begin
        case (an)
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
    end

    always_comb begin
        seen_upd      = seen;
        seen_upd[idx] = dec_ok;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= COLLECT;
            seen      <= 4'd0;
            cnt       <= 4'd0;
            prev      <= 11'd0;
            digits    <= 16'd0;
            out_valid <= 1'b0;
            err_code  <= 1'b0;
            err_ovf   <= 1'b0;
        end else begin
            err_code <= 1'b0;
            err_ovf  <= 1'b0;

            // Stability filter runs regardless of the handshake state.
            if (sample_en) begin
                if (!qualified) begin
                    cnt <= 4'd0;
                end else begin
                    prev <= sample;
                    if (!match)
                        cnt <= 4'd1;
                    else if (cnt != CNT_MAX)
                        cnt <= cnt + 4'd1;
                end
            end

            case (state)
                COLLECT: begin
                    if (accept) begin
                        seen <= seen_upd;
                        if (dec_ok)
                            digits[{idx, 2'b00} +: 4] <= dec_val;
                        else
                            err_code <= 1'b1;
                        if (seen_upd == 4'hF) begin
                            state     <= PRESENT;
                            out_valid <= 1'b1;
                        end
                    end
                end
                PRESENT: begin
                    if (accept)
                        err_ovf <= 1'b1;
                    if (out_valid && out_ready) begin
                        state     <= COLLECT;
                        seen      <= 4'd0;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= COLLECT;
                    seen      <= 4'd0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seven_segment_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_seven_segment_reader
// Description : Directed and randomized self-checking bench for
//               seven_segment_reader against a behavioural frame model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seven_segment_reader;

    localparam int STABLE = 4;
    localparam logic [6:0] PATS [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
                                         7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  display = 7'd0;
    logic [3:0]  an = 4'd0;
    logic        sample_en = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] bcd_out;
    logic        out_valid;
    logic        err_code;
    logic        err_ovf;

    int tests = 0;
    int fails = 0;

    // Behavioural model: run length of identical qualified samples and frame.
    logic [10:0] m_prev;
    int          m_run;
    logic [3:0]  m_dig [4];
    bit          m_seen [4];
    bit          m_valid;
    bit          m_code;
    bit          m_ovf;

    logic [3:0]  r_a;
    logic [6:0]  r_d;
    int          r_n;

    seven_segment_reader #(.STABLE_CNT(STABLE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .display   (display),
        .an        (an),
        .sample_en (sample_en),
        .bcd_out   (bcd_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err_code  (err_code),
        .err_ovf   (err_ovf)
    );

    always #5 clk = ~clk;

    function automatic bit decode(input logic [6:0] p, output logic [3:0] v);
        v = 4'h0;
        for (int i = 0; i < 10; i++)
            if (p == PATS[i]) begin
                v = 4'(i);
                return 1'b1;
            end
`ifdef SEG_READER_BLANK_EN
        if (p == 7'h00) begin
            v = 4'hF;
            return 1'b1;
        end
`endif
        return 1'b0;
    endfunction

    function automatic void model_reset();
        m_prev  = 11'd0;
        m_run   = 0;
        m_valid = 0;
        m_code  = 0;
        m_ovf   = 0;
        for (int i = 0; i < 4; i++) begin
            m_dig[i]  = 4'h0;
            m_seen[i] = 0;
        end
    endfunction

    function automatic void model_edge(input bit en, input logic [3:0] a,
                                       input logic [6:0] d, input bit rdy);
        bit         acc = 0;
        bit         ok;
        bit         all;
        logic [3:0] v;
        int         k = 0;
        m_code = 0;
        m_ovf  = 0;
        if (en) begin
            if ($countones(a) != 1) begin
                m_run = 0;
            end else begin
                if ({a, d} == m_prev) m_run++;
                else m_run = 1;
                m_prev = {a, d};
                acc = (m_run == STABLE);
            end
        end
        if (!m_valid) begin
            if (acc) begin
                for (int j = 0; j < 4; j++) if (a[j]) k = j;
                ok = decode(d, v);
                if (ok) m_dig[k] = v;
                m_seen[k] = ok;
                m_code = !ok;
                all = m_seen[0] && m_seen[1] && m_seen[2] && m_seen[3];
                if (all) m_valid = 1;
            end
        end else begin
            if (acc) m_ovf = 1;
            if (rdy) begin
                m_valid = 0;
                for (int j = 0; j < 4; j++) m_seen[j] = 0;
            end
        end
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "/bcd"},   bcd_out, {m_dig[3], m_dig[2], m_dig[1], m_dig[0]});
        check({tag, "/valid"}, 16'(out_valid), 16'(m_valid));
        check({tag, "/code"},  16'(err_code),  16'(m_code));
        check({tag, "/ovf"},   16'(err_ovf),   16'(m_ovf));
    endtask

    task automatic step(input bit en, input logic [3:0] a, input logic [6:0] d,
                        input bit rdy, input string tag);
        sample_en = en;
        an        = a;
        display   = d;
        out_ready = rdy;
        @(posedge clk);
        model_edge(en, a, d, rdy);
        #1;
        check_all(tag);
    endtask

    task automatic run(input logic [3:0] a, input logic [6:0] d, input int n, input string tag);
        for (int i = 0; i < n; i++) step(1'b1, a, d, 1'b0, tag);
    endtask

    initial begin
        model_reset();
        #12;
        check_all("reset");
        check("reset_bcd", bcd_out, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        // Test 1: full frame, consumer not ready, frame held
        run(4'b0001, 7'h30, 4, "t1");
        run(4'b0010, 7'h79, 4, "t1");
        run(4'b0100, 7'h7F, 4, "t1");
        run(4'b1000, 7'h7B, 4, "t1");
        check("t1_valid", 16'(out_valid), 16'd1);
        check("t1_bcd", bcd_out, 16'h9831);
        for (int i = 0; i < 3; i++) step(1'b0, 4'd0, 7'd0, 1'b0, "t1_hold");
        check("t1_hold_bcd", bcd_out, 16'h9831);

        // Test 4: overflow in PRESENT, then transfer
        run(4'b0001, 7'h6D, 4, "t4");
        check("t4_ovf", 16'(err_ovf), 16'd1);
        check("t4_bcd", bcd_out, 16'h9831);
        step(1'b0, 4'd0, 7'd0, 1'b1, "t4_xfer");
        check("t4_valid", 16'(out_valid), 16'd0);

        // Test 2: runs one sample short are never accepted
        run(4'b0001, 7'h30, 3, "t2");
        run(4'b0010, 7'h79, 3, "t2");
        run(4'b0100, 7'h7F, 3, "t2");
        run(4'b1000, 7'h7B, 3, "t2");
        check("t2_valid", 16'(out_valid), 16'd0);

        // Test 3: undecodable pattern on digit 0 blocks the frame
        run(4'b0001, 7'h01, 4, "t3");
        check("t3_code", 16'(err_code), 16'd1);
        run(4'b0010, 7'h5B, 4, "t3");
        run(4'b0100, 7'h33, 4, "t3");
        run(4'b1000, 7'h70, 4, "t3");
        check("t3_novalid", 16'(out_valid), 16'd0);
        run(4'b0001, 7'h7E, 4, "t3");
        check("t3_valid", 16'(out_valid), 16'd1);
        check("t3_bcd", bcd_out, 16'h7450);
        step(1'b0, 4'd0, 7'd0, 1'b1, "t3_xfer");

        // Test 5: a non-one-hot sample restarts the run
        run(4'b0001, 7'h30, 4, "t5");
        run(4'b0010, 7'h6D, 4, "t5");
        run(4'b0100, 7'h79, 4, "t5");
        run(4'b1000, 7'h33, 2, "t5");
        step(1'b1, 4'b0011, 7'h33, 1'b0, "t5_bad");
        run(4'b1000, 7'h33, 3, "t5");
        check("t5_wait", 16'(out_valid), 16'd0);
        run(4'b1000, 7'h33, 1, "t5");
        check("t5_valid", 16'(out_valid), 16'd1);
        check("t5_bcd", bcd_out, 16'h4321);
        step(1'b0, 4'd0, 7'd0, 1'b1, "t5_xfer");

        // Test 6: asynchronous reset mid-run
        run(4'b0001, 7'h5B, 4, "t6");
        run(4'b0010, 7'h33, 4, "t6");
        sample_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("t6_rst");
        check("t6_rst_bcd", bcd_out, 16'h0000);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        run(4'b0001, 7'h5F, 4, "t6");
        run(4'b0010, 7'h70, 4, "t6");
        run(4'b0100, 7'h7E, 4, "t6");
        check("t6_wait", 16'(out_valid), 16'd0);
        run(4'b1000, 7'h30, 4, "t6");
        check("t6_valid", 16'(out_valid), 16'd1);
        check("t6_bcd", bcd_out, 16'h1076);
        step(1'b0, 4'd0, 7'd0, 1'b1, "t6_xfer");

        run(4'b0001, 7'h00, 4, "blank");
        run(4'b0010, 7'h00, 4, "blank");
        run(4'b0100, 7'h00, 4, "blank");
        run(4'b1000, 7'h00, 4, "blank");
`ifdef SEG_READER_BLANK_EN
        check("blank_valid", 16'(out_valid), 16'd1);
        check("blank_bcd", bcd_out, 16'hFFFF);
        step(1'b0, 4'd0, 7'd0, 1'b1, "blank_xfer");
`else
        check("blank_valid", 16'(out_valid), 16'd0);
        check("blank_bcd", bcd_out, 16'h1076);
`endif

        // Randomized runs of repeated samples with noise and random ready
        for (int i = 0; i < 150; i++) begin
            r_a = 4'b0001 << $urandom_range(0, 3);
            if ($urandom_range(0, 7) == 0) r_a = 4'($urandom);
            r_d = PATS[$urandom_range(0, 9)];
            if ($urandom_range(0, 6) == 0) r_d = 7'($urandom);
            r_n = $urandom_range(1, 7);
            for (int k = 0; k < r_n; k++)
                step($urandom_range(0, 5) != 0, r_a, r_d, $urandom_range(0, 3) == 0, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
